cmd_exec_par: RTL

CMD_EXEC_PAR -- requirements
Module: cmd_exec_par

---
 rtl/cmd_exec_pkg.sv | 51 +++++
 rtl/cmd_fifo.sv | 82 ++++++++
 rtl/cmd_exec_par.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_exec_pkg.sv
// rtl/cmd_exec_pkg.sv - shared opcode, status, bus command and FSM constants
package cmd_exec_pkg;

    // Opcodes carried in CMD_DATA[top:top-2]
    localparam logic [2:0] OP_SET = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_CLR = 3'b011;
    localparam logic [2:0] OP_RD  = 3'b100;
    localparam logic [2:0] OP_BAD = 3'b101;
    localparam logic [2:0] OP_TGL = 3'b110;
    localparam logic [2:0] OP_WR  = 3'b111;

    // Completion status
    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_TMO   = 2'b01;
    localparam logic [1:0] ST_BADOP = 2'b10;

    // Peripheral bus command encodings
    localparam logic [2:0] SCMD_NONE = 3'b000;
    localparam logic [2:0] SCMD_RD   = 3'b100;
    localparam logic [2:0] SCMD_WR   = 3'b001;

    // Executor FSM states
    localparam logic [2:0] S_IDLE   = 3'b000;
    localparam logic [2:0] S_EXEC   = 3'b001;
    localparam logic [2:0] S_BUS_RD = 3'b010;
    localparam logic [2:0] S_GAP    = 3'b011;
    localparam logic [2:0] S_BUS_WR = 3'b100;
    localparam logic [2:0] S_RESP   = 3'b101;

    // How EXEC dispatches an opcode; RD shares the read phase with the
    // read-modify-write ops and simply skips the write
    typedef enum logic [1:0] {
        CLS_ALU = 2'b00,
        CLS_WR  = 2'b01,
        CLS_RMW = 2'b10,
        CLS_BAD = 2'b11
    } op_class_e;

    function automatic op_class_e op_class(input logic [2:0] op);
        case (op)
            OP_ADD, OP_MUL:                 op_class = CLS_ALU;
            OP_WR:                          op_class = CLS_WR;
            OP_SET, OP_CLR, OP_TGL, OP_RD:  op_class = CLS_RMW;
            OP_BAD:                         op_class = CLS_BAD;
            default:                        op_class = CLS_BAD;
        endcase
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - power-of-two command queue with registered full/empty
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("cmd_fifo DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Over/underflow requests are dropped rather than corrupting pointers
    assign do_push  = push && !full_q;
    assign do_pop   = pop && !empty_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;

    // Next pointers, occupancy and flags; pointers wrap naturally at DEPTH
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == (PTR_W+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Control state, cleared by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Payload storage needs no reset; only slots behind the pointers are read
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cmd_exec_par.sv
// rtl/cmd_exec_par.sv - queued command executor with ALU ops and peripheral bus RMW
module cmd_exec_par
    import cmd_exec_pkg::*;
#(
    parameter int ARG_W      = 64,
    parameter int ADDR_W     = 40,
    parameter int BD_W       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TMO        = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [3+2*ARG_W-1:0] CMD_DATA,
    output logic                 RES_VALID,
    input  logic                 RES_READY,
    output logic [5+ARG_W-1:0]   RES_DATA,
    output logic                 S_EX_REQ,
    input  logic                 S_EX_ACK,
    output logic [ADDR_W-1:0]    S_ADDR,
    output logic [2:0]           S_CMD,
    output logic [BD_W-1:0]      S_D_WR,
    input  logic [BD_W-1:0]      S_D_RD
);

    localparam int CMD_W = 3 + 2 * ARG_W;
    localparam int RES_W = 5 + ARG_W;
    localparam int TMO_W = $clog2(TMO + 1);

    if (ADDR_W + BD_W > ARG_W) begin : g_bad_width
        $error("cmd_exec_par requires ADDR_W + BD_W <= ARG_W");
    end
    if (TMO < 1) begin : g_bad_tmo
        $error("cmd_exec_par requires TMO >= 1");
    end

    logic             q_pop;
    logic [CMD_W-1:0] q_data;
    logic             q_full;
    logic             q_empty;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (CMD_VALID),
        .push_data (CMD_DATA),
        .pop       (q_pop),
        .pop_data  (q_data),
        .full      (q_full),
        .empty     (q_empty)
    );

    logic [2:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ARG_W-1:0]  a_q, a_d;
    logic [ARG_W-1:0]  b_q, b_d;
    logic [BD_W-1:0]   rd_q, rd_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              req_q, req_d;
    logic [2:0]        s_cmd_q, s_cmd_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [BD_W-1:0]   s_d_wr_q, s_d_wr_d;
    logic [RES_W-1:0]  res_data_q, res_data_d;

    logic [ARG_W-1:0]  sum;
    logic [ARG_W-1:0]  prod;
    logic [BD_W-1:0]   mask;
    logic [ADDR_W-1:0] addr;
    logic              tmo_hit;

    assign sum     = a_q + b_q;
    assign prod    = a_q * b_q;
    assign mask    = b_q[BD_W-1:0];
    assign addr    = b_q[ADDR_W+BD_W-1:BD_W];
    assign tmo_hit = (tmo_q == TMO_W'(TMO - 1));

    assign CMD_READY = !q_full;
    assign RES_VALID = (state_q == S_RESP);
    assign RES_DATA  = res_data_q;
    assign S_EX_REQ  = req_q;
    assign S_CMD     = s_cmd_q;
    assign S_ADDR    = s_addr_q;
    assign S_D_WR    = s_d_wr_q;

    // Executor FSM: pop, dispatch, bus read / gap / bus write with timeout, respond
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rd_d       = rd_q;
        tmo_d      = tmo_q;
        req_d      = req_q;
        s_cmd_d    = s_cmd_q;
        s_addr_d   = s_addr_q;
        s_d_wr_d   = s_d_wr_q;
        res_data_d = res_data_q;
        q_pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!q_empty) begin
                    q_pop   = 1'b1;
                    op_d    = q_data[CMD_W-1 -: 3];
                    a_d     = q_data[2*ARG_W-1:ARG_W];
                    b_d     = q_data[ARG_W-1:0];
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                case (op_class(op_q))
                    CLS_ALU: begin
                        res_data_d = {op_q, ST_OK, ((op_q == OP_MUL) ? prod : sum)};
                        state_d    = S_RESP;
                    end
                    CLS_WR: begin
                        s_addr_d = addr;
                        s_d_wr_d = mask;
                        s_cmd_d  = SCMD_WR;
                        req_d    = 1'b1;
                        tmo_d    = '0;
                        state_d  = S_BUS_WR;
                    end
                    CLS_RMW: begin
                        s_addr_d = addr;
                        s_cmd_d  = SCMD_RD;
                        req_d    = 1'b1;
                        tmo_d    = '0;
                        state_d  = S_BUS_RD;
                    end
                    default: begin
                        res_data_d = {op_q, ST_BADOP, {ARG_W{1'b0}}};
                        state_d    = S_RESP;
                    end
                endcase
            end

            S_BUS_RD: begin
                // ACK is checked before the timeout so a same-cycle ACK wins
                if (S_EX_ACK) begin
                    rd_d    = S_D_RD;
                    req_d   = 1'b0;
                    s_cmd_d = SCMD_NONE;
                    if (op_q == OP_RD) begin
                        res_data_d = {op_q, ST_OK, ARG_W'(S_D_RD)};
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_GAP;
                    end
                end else if (tmo_hit) begin
                    req_d      = 1'b0;
                    s_cmd_d    = SCMD_NONE;
                    res_data_d = {op_q, ST_TMO, {ARG_W{1'b0}}};
                    state_d    = S_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_GAP: begin
                // REQ stays low here for one cycle while the new byte is formed
                case (op_q)
                    OP_SET:  s_d_wr_d = rd_q | mask;
                    OP_CLR:  s_d_wr_d = rd_q & ~mask;
                    default: s_d_wr_d = rd_q ^ mask;
                endcase
                s_cmd_d = SCMD_WR;
                req_d   = 1'b1;
                tmo_d   = '0;
                state_d = S_BUS_WR;
            end

            S_BUS_WR: begin
                if (S_EX_ACK) begin
                    req_d      = 1'b0;
                    s_cmd_d    = SCMD_NONE;
                    res_data_d = {op_q, ST_OK, ARG_W'(s_d_wr_q)};
                    state_d    = S_RESP;
                end else if (tmo_hit) begin
                    req_d      = 1'b0;
                    s_cmd_d    = SCMD_NONE;
                    res_data_d = {op_q, ST_TMO, {ARG_W{1'b0}}};
                    state_d    = S_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_RESP: begin
                if (RES_READY) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Executor registers; reset drops REQ immediately, even mid bus phase
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rd_q       <= '0;
            tmo_q      <= '0;
            req_q      <= 1'b0;
            s_cmd_q    <= SCMD_NONE;
            s_addr_q   <= '0;
            s_d_wr_q   <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rd_q       <= rd_d;
            tmo_q      <= tmo_d;
            req_q      <= req_d;
            s_cmd_q    <= s_cmd_d;
            s_addr_q   <= s_addr_d;
            s_d_wr_q   <= s_d_wr_d;
            res_data_q <= res_data_d;
        end
    end

endmodule
